// File: rtl/move_selector.sv
// move_selector: drives a Monte Carlo statistics block once per first-move
// direction (up/right/down/left), collects the accumulated move count of each
// run and reports the direction with the highest total. A per-direction
// watchdog abandons runs whose trial count never reaches the limit.
module move_selector #(
    parameter int WD_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] board,
    input  logic [15:0] trial_limit,
    output logic        stat_rst,
    output logic [79:0] stat_board,
    output logic [1:0]  stat_dir,
    input  logic [31:0] stat_total,
    input  logic [31:0] stat_trials,
    output logic        busy,
    output logic        done,
    output logic [1:0]  best_dir,
    output logic [31:0] best_score,
    output logic        timeout
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CMP, FIN} state_t;

    localparam logic [WD_W-1:0] WD_MAX = '1;

    state_t          state_q, state_d;
    logic [79:0]     board_q, board_d;
    logic [15:0]     limit_q, limit_d;
    logic [1:0]      dir_q, dir_d;
    logic [31:0]     score_q, score_d;
    logic [31:0]     best_score_q, best_score_d;
    logic [1:0]      best_dir_q, best_dir_d;
    logic            timeout_q, timeout_d;
    logic            clr_cnt_q, clr_cnt_d;
    logic            first_q, first_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            stat_rst_q, stat_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            trials_met;

    // Limit is stored already forced to at least 1, so a plain compare suffices.
    assign trials_met = (stat_trials >= {16'd0, limit_q});

    // Next-state and datapath control for the per-direction evaluation sequence.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        limit_d      = limit_q;
        dir_d        = dir_q;
        score_d      = score_q;
        best_score_d = best_score_q;
        best_dir_d   = best_dir_q;
        timeout_d    = timeout_q;
        clr_cnt_d    = clr_cnt_q;
        first_d      = first_q;
        wd_d         = wd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    board_d      = board;
                    limit_d      = (trial_limit == 16'd0) ? 16'd1 : trial_limit;
                    dir_d        = 2'd0;
                    best_score_d = 32'd0;
                    best_dir_d   = 2'd0;
                    timeout_d    = 1'b0;
                    clr_cnt_d    = 1'b0;
                    state_d      = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q) begin
                    first_d = 1'b1;
                    wd_d    = '0;
                    state_d = RUN;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            RUN: begin
                first_d = 1'b0;
                if (first_q) begin
                    // Statistics outputs may still reflect the pre-clear run here.
                    wd_d = wd_q + WD_W'(1);
                end else if (trials_met) begin
                    score_d = stat_total;
                    state_d = CMP;
                end else if (wd_q == WD_MAX) begin
                    score_d   = 32'd0;
                    timeout_d = 1'b1;
                    state_d   = CMP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            CMP: begin
                // Strict compare: ties keep the earlier (lower) direction.
                if (score_q > best_score_q) begin
                    best_score_d = score_q;
                    best_dir_d   = dir_q;
                end
                if (dir_q != 2'd3) begin
                    dir_d     = dir_q + 2'd1;
                    clr_cnt_d = 1'b0;
                    state_d   = CLEAR;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stat_rst_d = (state_d == CLEAR);
        busy_d     = (state_d == CLEAR) || (state_d == RUN) || (state_d == CMP);
        done_d     = (state_d == FIN);
    end

    // State and output registers; reset puts the statistics block in reset too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            board_q      <= '0;
            limit_q      <= 16'd1;
            dir_q        <= 2'd0;
            score_q      <= 32'd0;
            best_score_q <= 32'd0;
            best_dir_q   <= 2'd0;
            timeout_q    <= 1'b0;
            clr_cnt_q    <= 1'b0;
            first_q      <= 1'b0;
            wd_q         <= '0;
            stat_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            limit_q      <= limit_d;
            dir_q        <= dir_d;
            score_q      <= score_d;
            best_score_q <= best_score_d;
            best_dir_q   <= best_dir_d;
            timeout_q    <= timeout_d;
            clr_cnt_q    <= clr_cnt_d;
            first_q      <= first_d;
            wd_q         <= wd_d;
            stat_rst_q   <= stat_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign stat_rst   = stat_rst_q;
    assign stat_board = board_q;
    assign stat_dir   = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_dir   = best_dir_q;
    assign best_score = best_score_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_move_selector.sv
// Testbench for move_selector with a behavioural statistics block model and a
// done-driven scoreboard. Watchdog width is shortened to keep runs brief.
module tb_move_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] board;
    logic [15:0] trial_limit;
    logic        stat_rst;
    logic [79:0] stat_board;
    logic [1:0]  stat_dir;
    logic [31:0] stat_total;
    logic [31:0] stat_trials;
    logic        busy;
    logic        done;
    logic [1:0]  best_dir;
    logic [31:0] best_score;
    logic        timeout;

    always #5 clk = ~clk;

    move_selector #(.WD_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .board       (board),
        .trial_limit (trial_limit),
        .stat_rst    (stat_rst),
        .stat_board  (stat_board),
        .stat_dir    (stat_dir),
        .stat_total  (stat_total),
        .stat_trials (stat_trials),
        .busy        (busy),
        .done        (done),
        .best_dir    (best_dir),
        .best_score  (best_score),
        .timeout     (timeout)
    );

    // Statistics block model: one trial per cycle unless the direction stalls.
    logic [31:0] m_totals [4];
    logic        m_never  [4];

    always @(posedge clk) begin
        if (stat_rst !== 1'b0) begin
            stat_trials <= 32'd0;
            stat_total  <= 32'd0;
        end else begin
            if (!m_never[stat_dir]) stat_trials <= stat_trials + 32'd1;
            stat_total <= m_totals[stat_dir];
        end
    end

    typedef struct {
        logic [1:0]  dir;
        logic [31:0] score;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_best_dir", 80'(best_dir), 80'(e.dir));
                check("sb_best_score", 80'(best_score), 80'(e.score));
                check("sb_timeout", 80'(timeout), 80'(e.to));
                check("sb_busy_low_at_done", 80'(busy), 80'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_only(input logic [79:0] b, input logic [15:0] lim);
        board       = b;
        trial_limit = lim;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic run_eval(input logic [79:0] b, input logic [15:0] lim,
                            input logic [1:0] edir, input logic [31:0] escore, input logic eto);
        exp_t e;
        e.dir   = edir;
        e.score = escore;
        e.to    = eto;
        exp_q.push_back(e);
        start_only(b, lim);
    endtask

    task automatic wait_done(input int maxc, input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < maxc) begin
            step();
            cyc++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_wait_expired actual=%0d required=<%0d", cyc, maxc);
        end
    endtask

    task automatic set_totals(input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] t2, input logic [31:0] t3);
        m_totals[0] = t0;
        m_totals[1] = t1;
        m_totals[2] = t2;
        m_totals[3] = t3;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        int done_snap;
        logic [79:0] b1;
        logic [79:0] b4;

        b1 = 80'h1234_5678_9ABC_DEF0_1111;
        b4 = 80'hFEDC_BA98_7654_3210_ABCD;
        rst = 1'b0;
        start = 1'b0;
        board = '0;
        trial_limit = 16'd0;
        set_totals(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) m_never[i] = 1'b0;

        // Reset state.
        step();
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_done", 80'(done), 80'd0);
        check("rst_timeout", 80'(timeout), 80'd0);
        check("rst_best_dir", 80'(best_dir), 80'd0);
        check("rst_best_score", 80'(best_score), 80'd0);
        check("rst_stat_rst", 80'(stat_rst), 80'd1);
        check("rst_stat_dir", 80'(stat_dir), 80'd0);
        check("rst_stat_board", stat_board, 80'd0);
        step();
        rst = 1'b1;
        step();
        check("post_rst_stat_rst", 80'(stat_rst), 80'd0);
        check("post_rst_busy", 80'(busy), 80'd0);

        // Basic: tie on 40 keeps direction 1; latency 4*(2+5+1)+1.
        set_totals(10, 40, 25, 40);
        run_eval(b1, 16'd4, 2'd1, 32'd40, 1'b0);
        check("t1_busy", 80'(busy), 80'd1);
        check("t1_stat_rst", 80'(stat_rst), 80'd1);
        check("t1_stat_board", stat_board, b1);
        wait_done(200, 1, cyc);
        check("t1_latency", 80'(cyc), 80'd33);
        step();
        check("t1_done_single", 80'(done), 80'd0);

        // All zero totals.
        set_totals(0, 0, 0, 0);
        run_eval(80'h5, 16'd2, 2'd0, 32'd0, 1'b0);
        wait_done(200, 1, cyc);
        step();

        // Watchdog on direction 2.
        set_totals(3, 4, 99, 5);
        m_never[2] = 1'b1;
        run_eval(80'hABC, 16'd3, 2'd3, 32'd5, 1'b1);
        wait_done(1000, 1, cyc);
        step();
        m_never[2] = 1'b0;
        check("t3_timeout_sticky", 80'(timeout), 80'd1);

        // Limit zero behaves as one; start pulses while busy are ignored.
        set_totals(7, 2, 9, 9);
        done_snap = done_cnt;
        run_eval(80'h77, 16'd0, 2'd2, 32'd9, 1'b0);
        check("t4_timeout_cleared", 80'(timeout), 80'd0);
        repeat (3) step();
        board = 80'h99;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(200, 5, cyc);
        check("t4_latency", 80'(cyc), 80'd21);
        repeat (10) step();
        check("t4_one_done", 80'(done_cnt - done_snap), 80'd1);
        check("t4_no_restart", 80'(busy), 80'd0);

        // Asynchronous reset during direction 1 RUN.
        set_totals(10, 40, 25, 40);
        done_snap = done_cnt;
        start_only(b1, 16'd4);
        n = 0;
        while (!(stat_dir == 2'd1 && busy && !stat_rst) && n < 200) begin
            step();
            n++;
        end
        check("t5_reached_dir1_run", 80'(n < 200), 80'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_busy", 80'(busy), 80'd0);
        check("t5_stat_rst", 80'(stat_rst), 80'd1);
        check("t5_stat_dir", 80'(stat_dir), 80'd0);
        check("t5_stat_board", stat_board, 80'd0);
        check("t5_best_score", 80'(best_score), 80'd0);
        check("t5_done", 80'(done), 80'd0);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("t5_release_stat_rst", 80'(stat_rst), 80'd0);
        check("t5_release_busy", 80'(busy), 80'd0);
        check("t5_no_done", 80'(done_cnt - done_snap), 80'd0);
        run_eval(b1, 16'd4, 2'd1, 32'd40, 1'b0);
        wait_done(200, 1, cyc);
        check("t5_full_latency", 80'(cyc), 80'd33);

        // Back-to-back: start held across FIN (ignored) and the next IDLE (accepted).
        set_totals(1, 1, 1, 50);
        begin
            exp_t e;
            e.dir   = 2'd3;
            e.score = 32'd50;
            e.to    = 1'b0;
            exp_q.push_back(e);
        end
        board       = b4;
        trial_limit = 16'd1;
        start       = 1'b1;
        step();
        check("t6_fin_start_ignored", 80'(busy), 80'd0);
        check("t6_idle_stat_rst", 80'(stat_rst), 80'd0);
        step();
        start = 1'b0;
        check("t6_accepted", 80'(busy), 80'd1);
        check("t6_new_board", stat_board, b4);
        check("t6_clear1_stat_rst", 80'(stat_rst), 80'd1);
        step();
        check("t6_clear2_stat_rst", 80'(stat_rst), 80'd1);
        step();
        check("t6_run_stat_rst", 80'(stat_rst), 80'd0);
        wait_done(200, 3, cyc);
        check("t6_latency", 80'(cyc), 80'd21);
        repeat (3) step();
        check("sb_all_consumed", 80'(exp_q.size()), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_selector.md
MOVE_SELECTOR -- requirements
Module: move_selector

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-003 start  input  1  one-cycle request to evaluate the captured board; honoured only in IDLE.
REQ-004 board  input  80  16 tiles x 5 bits; sampled on the accepted start cycle.
REQ-005 trial_limit  input  16  trials run per direction; value 0 treated as 1; sampled with board.
REQ-006 stat_rst  output  1  active-high reset to the Monte Carlo statistics block.
REQ-007 stat_board  output  80  captured board, driven to the statistics block.
REQ-008 stat_dir  output  2  first-move direction under test (0=up, 1=right, 2=down, 3=left).
REQ-009 stat_total  input  32  accumulated move count from the statistics block.
REQ-010 stat_trials  input  32  completed trial count from the statistics block.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse when the result is valid.
REQ-013 best_dir  output  2  winning direction; held until the next done.
REQ-014 best_score  output  32  stat_total of the winning direction; held until the next done.
REQ-015 timeout  output  1  sticky flag: at least one direction hit the watchdog during the last evaluation.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, CLEAR, RUN, CMP, FIN.
- IDLE: start=1 -> capture board and trial_limit; dir=0; best_score=0; best_dir=0; clear timeout; go to CLEAR.
REQ-017 CLEAR SHALL assert stat_rst for exactly 2 cycles with stat_dir stable, then go to RUN.
REQ-018 RUN SHALL deassert stat_rst and wait until stat_trials >= trial_limit (32-bit unsigned compare, limit zero-extended), then latch stat_total into score and go to CMP.
- RUN SHALL ignore stat_total and stat_trials during the first RUN cycle, so no stale pre-reset value is accepted.
REQ-019 A 24-bit watchdog SHALL count RUN cycles. On reaching 2^24-1: score=0, timeout=1, go to CMP.
REQ-020 CMP SHALL update best_score/best_dir only if score > best_score (strict).
- Ties keep the lower direction index.
- All scores 0 -> best_dir=0.
REQ-021 After CMP: dir<3 -> increment dir, go to CLEAR; dir=3 -> go to FIN.
REQ-022 FIN SHALL pulse done for 1 cycle, drop busy in the same cycle, and return to IDLE.
- best_dir and best_score SHALL update visibly no later than the done cycle.
REQ-023 start SHALL be ignored in CLEAR, RUN, CMP and FIN.
- start in the FIN cycle SHALL be ignored.
- start in the first IDLE cycle after FIN SHALL be accepted.
REQ-024 stat_board and stat_dir SHALL remain constant throughout CLEAR and RUN for a given direction.
REQ-025 Latency SHALL be 4 x (2 CLEAR + RUN cycles + 1 CMP) + 1 FIN cycles after the start cycle.

Reset
REQ-026 rst=0 SHALL force the following outputs immediately:
- state=IDLE, busy=0, done=0, timeout=0, best_dir=0, best_score=0
- stat_rst=1, stat_dir=0, stat_board=0, watchdog=0
REQ-027 rst asserted mid-evaluation SHALL abort it with no done pulse.
- After rst release, the block SHALL sit in IDLE with stat_rst=0 from the first clk edge.

Verification
REQ-028 Basic: start; limit=4; model reports totals {10,40,25,40} -> best_dir=1, best_score=40, done pulse once, timeout=0.
REQ-029 All zero: totals {0,0,0,0} -> best_dir=0, best_score=0.
REQ-030 Watchdog: dir 2 model never completes trials; dir 3 total 5 -> dir 2 score 0, timeout=1, best_dir=3 if the others report <5.
REQ-031 limit=0: each direction completes when stat_trials>=1; start pulsed while busy -> no restart, exactly one done.
REQ-032 Reset: rst=0 during dir 1 RUN -> busy=0, stat_rst=1 immediately, no done; new start after release -> full 4-direction evaluation.
REQ-033 Back-to-back: start in the cycle after done -> accepted, new board appears on stat_board, CLEAR asserts stat_rst for 2 cycles.
